// File: rtl/capture_scheduler_pkg.sv
// Shared types and constants for the frame capture scheduler.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      STREAM   = 2'd2,
      ABORT    = 2'd3
   } state_t;

   localparam logic CAM_HAWK = 1'b0;
   localparam logic CAM_OWL  = 1'b1;

   localparam logic [7:0] TKEEP_ALL = 8'hFF;

endpackage

// File: rtl/capture_scheduler_if.sv
// AXI-Stream style bundle used for both camera inputs and the DMA output.
interface capture_stream_if #(
   parameter int W = 64
);
   logic [W-1:0]   tdata;
   logic [W/8-1:0] tkeep;
   logic           tvalid;
   logic           tuser;
   logic           tlast;
   logic           tready;

   modport master (
      output tdata, tkeep, tvalid, tuser, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tuser, tlast,
      output tready
   );
endinterface

// File: rtl/capture_scheduler_watchdog.sv
// Idle-cycle watchdog: fires on the cycle the count would reach the limit.
module capture_watchdog #(
   parameter int TO_W = 32
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic            i_en,
   input  logic            i_clr,
   input  logic [TO_W-1:0] i_limit,
   output logic            o_fire
);
   localparam logic [TO_W-1:0] ONE = TO_W'(1);

   logic [TO_W-1:0] r_cnt;
   logic            w_run;

   assign w_run  = i_en && (i_limit != '0);
   assign o_fire = w_run && !i_clr && (r_cnt == i_limit - ONE);

   always_ff @(posedge sys_clk) begin
      if (sys_rst || !w_run || i_clr) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + ONE;
      end
   end
endmodule

// File: rtl/capture_scheduler.sv
// One frame per capture request; arbitrates Hawk/Owl onto the S2MM stream.
module capture_scheduler
   import capture_pkg::*;
#(
   parameter int TDATA_W      = 64,
   parameter int PIX_PER_BEAT = 4,
   parameter int TO_W         = 32
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             capture,
   input  logic             camera_sel,
   input  logic [15:0]      hawk_width,
   input  logic [15:0]      hawk_height,
   input  logic [15:0]      owl_width,
   input  logic [15:0]      owl_height,
   input  logic [TO_W-1:0]  timeout_cycles,
   capture_stream_if.slave  hawk,
   capture_stream_if.slave  owl,
   capture_stream_if.master m_axis,
   output logic             in_progress,
   output logic             capture_done,
   output logic             timeout_err,
   output logic             cfg_err,
   output logic [15:0]      frame_count
);
   localparam int SH = $clog2(PIX_PER_BEAT);

   state_t        r_state;
   logic          r_sel;
   logic [30:0]   r_total;
   logic [30:0]   r_beat;
   logic          r_done;
   logic          r_terr;
   logic          r_cerr;
   logic [15:0]   r_fcnt;

   logic [15:0]   w_width;
   logic [15:0]   w_height;
   logic [32:0]   w_round;
   logic [30:0]   w_total;
   logic          w_cfg_ok;

   logic [TDATA_W-1:0] w_sd;
   logic          w_sv;
   logic          w_su;
   logic          w_sel_tready;
   logic          w_hs;
   logic          w_last;
   logic          w_fire;
   logic          w_wd_en;
   logic [TDATA_W-1:0] w_md;
   logic          w_mv;
   logic          w_ml;

   assign w_width  = camera_sel ? owl_width  : hawk_width;
   assign w_height = camera_sel ? owl_height : hawk_height;
   assign w_cfg_ok = (w_width != '0) && (w_height != '0);
   assign w_round  = {1'b0, 32'(w_width) * 32'(w_height)}
                   + 33'(PIX_PER_BEAT - 1);
   assign w_total  = 31'(w_round >> SH);

   assign w_sd   = (r_sel == CAM_OWL) ? owl.tdata  : hawk.tdata;
   assign w_sv   = (r_sel == CAM_OWL) ? owl.tvalid : hawk.tvalid;
   assign w_su   = (r_sel == CAM_OWL) ? owl.tuser  : hawk.tuser;
   assign w_last = (r_beat == r_total - 31'd1);

   always_comb begin
      w_sel_tready = 1'b1;
      w_hs         = 1'b0;
      w_mv         = 1'b0;
      w_md         = '0;
      w_ml         = 1'b0;
      unique case (1'b1)
         (r_state == WAIT_SOF): begin
            // the SOF beat is held back so it becomes the first output beat
            w_sel_tready = !(w_sv && w_su);
            w_hs         = w_sv && !w_su;
         end
         (r_state == STREAM): begin
            w_sel_tready = m_axis.tready;
            w_hs         = w_sv && m_axis.tready;
            w_mv         = w_sv;
            w_md         = w_sd;
            w_ml         = w_last;
         end
         (r_state == ABORT): begin
            w_sel_tready = 1'b0;
            w_mv         = 1'b1;
            w_ml         = 1'b1;
         end
         default: ;
      endcase
   end

   assign hawk.tready = (r_state != IDLE && r_sel == CAM_HAWK)
                      ? w_sel_tready : 1'b1;
   assign owl.tready  = (r_state != IDLE && r_sel == CAM_OWL)
                      ? w_sel_tready : 1'b1;

   assign m_axis.tvalid = w_mv;
   assign m_axis.tdata  = w_md;
   assign m_axis.tlast  = w_ml;
   assign m_axis.tkeep  = TKEEP_ALL;
   assign m_axis.tuser  = 1'b0;

   assign w_wd_en = (r_state == WAIT_SOF) || (r_state == STREAM);

   capture_watchdog #(.TO_W(TO_W)) u_wd (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .i_en    (w_wd_en),
      .i_clr   (w_hs),
      .i_limit (timeout_cycles),
      .o_fire  (w_fire)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= IDLE;
         r_sel   <= CAM_HAWK;
         r_total <= '0;
         r_beat  <= '0;
         r_done  <= 1'b0;
         r_terr  <= 1'b0;
         r_cerr  <= 1'b0;
         r_fcnt  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (capture && w_cfg_ok) begin
                  r_sel   <= camera_sel;
                  r_total <= w_total;
                  r_beat  <= '0;
                  r_terr  <= 1'b0;
                  r_cerr  <= 1'b0;
                  r_state <= WAIT_SOF;
               end else if (capture) begin
                  r_cerr <= 1'b1;
               end
            end
            WAIT_SOF: begin
               if (w_fire) begin
                  r_terr  <= 1'b1;
                  r_state <= IDLE;
               end else if (w_sv && w_su) begin
                  r_state <= STREAM;
               end
            end
            STREAM: begin
               if (w_hs) begin
                  r_beat <= r_beat + 31'd1;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_fcnt  <= r_fcnt + 16'd1;
                     r_state <= IDLE;
                  end
               end else if (w_fire) begin
                  r_terr  <= 1'b1;
                  r_state <= ABORT;
               end
            end
            ABORT: begin
               if (m_axis.tready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_progress  = (r_state != IDLE);
   assign capture_done = r_done;
   assign timeout_err  = r_terr;
   assign cfg_err      = r_cerr;
   assign frame_count  = r_fcnt;
endmodule

// File: tb/tb_capture_scheduler.sv
// Scoreboard bench: expected output beats are queued, a monitor pops them.
module tb_capture_scheduler;
   typedef struct packed {
      logic [63:0] d;
      logic        u;
   } beat_t;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
   } exp_t;

   logic        sys_clk;
   logic        sys_rst;
   logic        capture;
   logic        camera_sel;
   logic [15:0] hawk_width, hawk_height, owl_width, owl_height;
   logic [31:0] timeout_cycles;
   logic        in_progress, capture_done, timeout_err, cfg_err;
   logic [15:0] frame_count;

   capture_stream_if hawk_if ();
   capture_stream_if owl_if ();
   capture_stream_if m_if ();

   capture_scheduler dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .capture        (capture),
      .camera_sel     (camera_sel),
      .hawk_width     (hawk_width),
      .hawk_height    (hawk_height),
      .owl_width      (owl_width),
      .owl_height     (owl_height),
      .timeout_cycles (timeout_cycles),
      .hawk           (hawk_if.slave),
      .owl            (owl_if.slave),
      .m_axis         (m_if.master),
      .in_progress    (in_progress),
      .capture_done   (capture_done),
      .timeout_err    (timeout_err),
      .cfg_err        (cfg_err),
      .frame_count    (frame_count)
   );

   beat_t h_q[$];
   beat_t o_q[$];
   exp_t  exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    done_cnt = 0;
   int    exp_done = 0;
   bit    h_gap = 0;
   bit    o_gap = 0;
   bit    m_rand = 0;

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s act=%h req=%h", n, a, e);
      end
   endfunction

   initial begin : hawk_drv
      logic fire;
      hawk_if.tvalid = 0; hawk_if.tdata = '0; hawk_if.tuser = 0;
      hawk_if.tkeep = '1; hawk_if.tlast = 0;
      forever begin
         @(negedge sys_clk);
         fire = hawk_if.tvalid && hawk_if.tready;
         @(posedge sys_clk); #1;
         if (fire && h_q.size() > 0) void'(h_q.pop_front());
         if (h_q.size() > 0 && !(h_gap && $urandom_range(0, 2) == 0)) begin
            hawk_if.tvalid = 1;
            hawk_if.tdata  = h_q[0].d;
            hawk_if.tuser  = h_q[0].u;
         end else begin
            hawk_if.tvalid = 0;
            hawk_if.tuser  = 0;
         end
      end
   end

   initial begin : owl_drv
      logic fire;
      owl_if.tvalid = 0; owl_if.tdata = '0; owl_if.tuser = 0;
      owl_if.tkeep = '1; owl_if.tlast = 0;
      forever begin
         @(negedge sys_clk);
         fire = owl_if.tvalid && owl_if.tready;
         @(posedge sys_clk); #1;
         if (fire && o_q.size() > 0) void'(o_q.pop_front());
         if (o_q.size() > 0 && !(o_gap && $urandom_range(0, 2) == 0)) begin
            owl_if.tvalid = 1;
            owl_if.tdata  = o_q[0].d;
            owl_if.tuser  = o_q[0].u;
         end else begin
            owl_if.tvalid = 0;
            owl_if.tuser  = 0;
         end
      end
   end

   initial begin : rdy_drv
      m_if.tready = 1'b1;
      forever begin
         @(posedge sys_clk); #1;
         m_if.tready = m_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (capture_done) done_cnt++;
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL beat_unexpected act=%h last=%b req=none",
                        m_if.tdata, m_if.tlast);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_if.tdata, e.d);
               chk("beat_last", 64'(m_if.tlast), 64'(e.l));
               chk("beat_keep", 64'(m_if.tkeep), 64'hFF);
            end
         end
      end
   end

   task automatic pulse_capture(input logic sel);
      @(posedge sys_clk); #1;
      camera_sel = sel;
      capture = 1'b1;
      @(posedge sys_clk); #1;
      capture = 1'b0;
   endtask

   task automatic wait_idle(input string n, input int bound);
      int i = 0;
      while (in_progress && i < bound) begin
         @(negedge sys_clk);
         i++;
      end
      chk(n, 64'(in_progress), 64'd0);
   endtask

   task automatic wait_exp(input string n, input int tgt, input int bound);
      int i = 0;
      while (exp_q.size() > tgt && i < bound) begin
         @(negedge sys_clk);
         i++;
      end
      chk(n, 64'(exp_q.size() <= tgt), 64'd1);
   endtask

   task automatic push_frame(input bit owl, input logic [63:0] base,
                             input int n);
      for (int i = 1; i <= n; i++) begin
         if (owl) o_q.push_back('{base + 64'(i), i == 1});
         else     h_q.push_back('{base + 64'(i), i == 1});
      end
   endtask

   task automatic expect_frame(input logic [63:0] base, input int n,
                               input int total);
      for (int i = 1; i <= n; i++)
         exp_q.push_back('{base + 64'(i), i == total});
   endtask

   localparam logic [63:0] HB = 64'hA000_0000_0000_0000;
   localparam logic [63:0] OB = 64'hB000_0000_0000_0000;

   initial begin : main
      int cnt;
      bit seen;
      sys_rst = 1; capture = 0; camera_sel = 0;
      hawk_width = 16'd8; hawk_height = 16'd4;
      owl_width = 16'd5; owl_height = 16'd1;
      timeout_cycles = 32'd1000;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 0;
      @(negedge sys_clk);
      chk("rst_in_progress", 64'(in_progress), 0);
      chk("rst_tvalid", 64'(m_if.tvalid), 0);
      chk("rst_done", 64'(capture_done), 0);
      chk("rst_terr", 64'(timeout_err), 0);
      chk("rst_cerr", 64'(cfg_err), 0);
      chk("rst_fcnt", 64'(frame_count), 0);
      chk("rst_tkeep", 64'(m_if.tkeep), 64'hFF);

      // Hawk 8x4: junk then an 8-beat frame
      pulse_capture(1'b0);
      for (int i = 0; i < 3; i++) h_q.push_back('{HB + 64'hF0 + 64'(i), 1'b0});
      push_frame(0, HB, 8);
      expect_frame(HB, 8, 8);
      exp_done++;
      wait_idle("t1_idle", 200);
      repeat (3) @(negedge sys_clk);
      chk("t1_exp_empty", 64'(exp_q.size()), 0);
      chk("t1_done", 64'(done_cnt), 64'(exp_done));
      chk("t1_fcnt", 64'(frame_count), 1);

      // Owl 5x1 -> 2 beats with gaps; Hawk traffic drained
      m_rand = 1; o_gap = 1;
      pulse_capture(1'b1);
      for (int i = 0; i < 6; i++) h_q.push_back('{HB + 64'h50 + 64'(i), i[0]});
      o_q.push_back('{OB + 64'hF0, 1'b0});
      push_frame(1, OB, 3);
      expect_frame(OB, 2, 2);
      exp_done++;
      wait_idle("t2_idle", 300);
      repeat (10) @(negedge sys_clk);
      chk("t2_exp_empty", 64'(exp_q.size()), 0);
      chk("t2_hawk_drained", 64'(h_q.size()), 0);
      chk("t2_done", 64'(done_cnt), 64'(exp_done));
      chk("t2_fcnt", 64'(frame_count), 2);
      m_rand = 0; o_gap = 0;

      // Owl 16x16 stalls after beat 10 -> abort beat
      owl_width = 16'd16; owl_height = 16'd16; timeout_cycles = 32'd20;
      pulse_capture(1'b1);
      push_frame(1, OB + 64'h100, 10);
      expect_frame(OB + 64'h100, 10, 64);
      exp_q.push_back('{64'd0, 1'b1});
      wait_idle("t3_idle", 300);
      chk("t3_exp_empty", 64'(exp_q.size()), 0);
      chk("t3_terr", 64'(timeout_err), 1);
      chk("t3_done", 64'(done_cnt), 64'(exp_done));
      chk("t3_fcnt", 64'(frame_count), 2);

      // No SOF: watchdog returns to IDLE after exactly 20 cycles
      pulse_capture(1'b0);
      cnt = 0; seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (m_if.tvalid) seen = 1;
         if (in_progress) cnt++;
      end
      chk("t4_wait_cycles", 64'(cnt), 20);
      chk("t4_no_tvalid", 64'(seen), 0);
      chk("t4_terr", 64'(timeout_err), 1);

      // Watchdog disabled: stays in WAIT_SOF
      timeout_cycles = 32'd0;
      pulse_capture(1'b0);
      @(negedge sys_clk);
      chk("t4b_terr_clr", 64'(timeout_err), 0);
      repeat (100) @(negedge sys_clk);
      chk("t4b_still_wait", 64'(in_progress), 1);
      timeout_cycles = 32'd5;
      wait_idle("t4b_idle", 50);
      chk("t4b_terr", 64'(timeout_err), 1);

      // Zero width rejected; capture mid-STREAM ignored
      timeout_cycles = 32'd0;
      hawk_width = 16'd0;
      pulse_capture(1'b0);
      @(negedge sys_clk);
      chk("t5_cerr", 64'(cfg_err), 1);
      chk("t5_no_start", 64'(in_progress), 0);
      hawk_width = 16'd8;
      pulse_capture(1'b0);
      @(negedge sys_clk);
      chk("t5_cerr_clr", 64'(cfg_err), 0);
      h_gap = 1;
      push_frame(0, HB + 64'h200, 8);
      expect_frame(HB + 64'h200, 8, 8);
      exp_done++;
      wait_exp("t5_first_beat", 7, 200);
      pulse_capture(1'b1);
      wait_idle("t5_idle", 300);
      repeat (3) @(negedge sys_clk);
      chk("t5_exp_empty", 64'(exp_q.size()), 0);
      chk("t5_done", 64'(done_cnt), 64'(exp_done));
      chk("t5_fcnt", 64'(frame_count), 3);
      h_gap = 0;

      // Reset at beat 5 of 64, then a normal frame
      hawk_width = 16'd16; hawk_height = 16'd16;
      pulse_capture(1'b0);
      push_frame(0, HB + 64'h300, 64);
      expect_frame(HB + 64'h300, 64, 64);
      wait_exp("t6_five_beats", 59, 200);
      @(posedge sys_clk); #1;
      sys_rst = 1;
      @(posedge sys_clk); #1;
      sys_rst = 0;
      h_q.delete();
      exp_q.delete();
      @(negedge sys_clk);
      chk("t6_rst_inprog", 64'(in_progress), 0);
      chk("t6_rst_tvalid", 64'(m_if.tvalid), 0);
      chk("t6_rst_fcnt", 64'(frame_count), 0);
      chk("t6_rst_terr", 64'(timeout_err), 0);
      repeat (3) @(negedge sys_clk);
      hawk_width = 16'd8; hawk_height = 16'd4;
      pulse_capture(1'b0);
      push_frame(0, HB + 64'h400, 8);
      expect_frame(HB + 64'h400, 8, 8);
      exp_done++;
      wait_idle("t6_idle", 200);
      repeat (3) @(negedge sys_clk);
      chk("t6_exp_empty", 64'(exp_q.size()), 0);
      chk("t6_done", 64'(done_cnt), 64'(exp_done));
      chk("t6_fcnt", 64'(frame_count), 1);

      // total == 1: first beat carries tlast
      owl_width = 16'd4; owl_height = 16'd1;
      pulse_capture(1'b1);
      push_frame(1, OB + 64'h500, 1);
      expect_frame(OB + 64'h500, 1, 1);
      exp_done++;
      wait_idle("t7_idle", 100);
      repeat (3) @(negedge sys_clk);
      chk("t7_exp_empty", 64'(exp_q.size()), 0);
      chk("t7_done", 64'(done_cnt), 64'(exp_done));
      chk("t7_fcnt", 64'(frame_count), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
